// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared frame layout, defaults and frame check for the PS/2 receiver
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;

  localparam int START_BIT  = 0;
  localparam int DATA_LSB   = 1;
  localparam int DATA_MSB   = 8;
  localparam int PARITY_BIT = 9;
  localparam int STOP_BIT   = 10;

  localparam int DEFAULT_FIFO_DEPTH     = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

  typedef logic [DATA_MSB-DATA_LSB:0] scan_code_t;

  // bits holds start..parity; the stop bit is checked live as it arrives.
  function automatic logic frame_ok(input logic [PS2_FRAME_BITS-2:0] bits, input logic stop);
    return (bits[START_BIT] == 1'b0) && stop && (^bits[PARITY_BIT:DATA_LSB]);
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - synchronous scan-code FIFO with count-based full/empty
module ps2_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the registered count, so a same-cycle pop never rescues a push.
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - host-side PS/2 receiver: synchroniser, deframer, timeout and scan-code FIFO
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [2:0]                  s_clk;
  logic [2:0]                  s_data;
  logic                        fe;
  logic                        bit_in;
  logic [3:0]                  cnt;
  logic [PS2_FRAME_BITS-2:0]   shift_buf;
  logic [TW-1:0]               timer;
  logic                        frame_done;
  logic                        frame_good;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        pop;

  assign fe         = s_clk[2] & ~s_clk[1];
  assign bit_in     = s_data[1];
  assign frame_done = fe && (cnt == 4'(STOP_BIT));
  assign frame_good = frame_done && frame_ok(shift_buf, bit_in);
  assign ready      = (fifo_count != '0);
  assign pop        = ~nextdata_n & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      s_clk     <= 3'b111;
      s_data    <= 3'b111;
      cnt       <= '0;
      shift_buf <= '0;
      timer     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      s_clk     <= {s_clk[1:0], ps2_clk};
      s_data    <= {s_data[1:0], ps2_data};
      frame_err <= frame_done && !frame_good;
      if (frame_good && fifo_full) overflow <= 1'b1;

      if (fe) begin
        timer <= '0;
        if (frame_done) begin
          cnt <= '0;
        end else begin
          shift_buf[cnt] <= bit_in;
          cnt            <= cnt + 1'b1;
        end
      end else if (cnt != '0) begin
        // A stalled device leaves a partial frame; drop it silently and rearm.
        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          cnt   <= '0;
          timer <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .clrn      (clrn),
    .push      (frame_good),
    .push_data (shift_buf[DATA_MSB:DATA_LSB]),
    .pop       (pop),
    .pop_data  (data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Synthesizable host-side PS/2 receiver: the far end of the keyboard device model that drives ps2_clk/ps2_data.
- Samples the device-driven PS/2 clock and data in the system clock domain.
- Deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and validates them.
- Buffers valid scan codes in a small FIFO drained by the consumer via an active-low next-data strobe.

Parameters:
- FIFO_DEPTH, 8, number of scan-code entries; must be a power of two, at least 2.
- TIMEOUT_CYCLES, 4096, clk cycles without a PS/2 falling edge, mid-frame, before the deframer abandons the partial frame.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clrn  input  1  reset; synchronous, active-low.
- ps2_clk  input  1  PS/2 clock from the device; asynchronous to clk; idle high.
- ps2_data  input  1  PS/2 data from the device; asynchronous to clk.
- nextdata_n  input  1  active-low pop strobe; each clk cycle it is low while ready=1 pops one entry.
- data  output  8  scan code at the FIFO head; valid only while ready=1.
- ready  output  1  FIFO non-empty.
- overflow  output  1  sticky; set when a valid frame is dropped because the FIFO is full.
- frame_err  output  1  one-cycle pulse when a completed frame fails the start, parity or stop check.

Behaviour:
- Reset (clrn=0 at a clk edge):
  - clears the FIFO pointers and entry count, bit counter, shift buffer, timeout counter and overflow.
  - loads the synchroniser flops with 1 for ps2_clk and 1 for ps2_data.
  - resulting outputs: ready=0, overflow=0, frame_err=0, data=8'h00 (head entry register cleared).
  - a frame in flight when reset asserts is discarded; reception restarts at the next start bit after release.
- Synchronisation:
  - ps2_clk and ps2_data each pass through a 3-flop chain, s[0] to s[2].
  - falling edge detect: fe = s_clk[2] & ~s_clk[1].
  - the data bit is sampled from s_data[1] in the fe cycle, aligned to s_clk[1].
- Deframer:
  - bit counter cnt runs 0..10.
  - on fe with cnt<10: store the sampled bit into buf[cnt], then cnt+1.
  - on fe with cnt==10 the frame is complete. Checks: buf[0]==0 (start), sampled bit==1 (stop), ^buf[9:1]==1 (odd parity over data and parity bit). cnt returns to 0 in every case.
  - valid frame and FIFO not full: push buf[8:1] in the same cycle; ready is visible the next cycle.
  - valid frame and FIFO full: drop the frame and set overflow=1. overflow holds until reset.
  - invalid frame: drop it and assert frame_err for exactly one cycle; no push.
- Timeout:
  - the counter clears on every fe and counts while cnt!=0.
  - when it reaches TIMEOUT_CYCLES-1 without an fe: cnt returns to 0 and the counter clears; no frame_err.
- FIFO:
  - holds up to FIFO_DEPTH entries, tracked by a count register (log2(FIFO_DEPTH)+1 bits).
  - pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - data = mem[rd_ptr], combinational from registered state.
  - pop: nextdata_n==0 && ready; rd_ptr+1 and count-1. nextdata_n low while empty is ignored.
  - holding nextdata_n low for several cycles pops one entry per cycle.
  - simultaneous push and pop when 0<count<FIFO_DEPTH: count is unchanged and both pointers advance.
  - full is evaluated on the registered count. A push in a full cycle is dropped (overflow set) even if a pop happens in that same cycle.
  - a push while empty makes ready=1 the next cycle, with data equal to the pushed code.
- Latency: ready rises at most 4 clk cycles after the 11th ps2_clk falling edge at the pin (3 synchroniser stages + 1 push register).
- Maximum PS/2 clock supported: ps2_clk high and low phases are each at least 4 clk cycles.

Decomposition:
- Shared package ps2_pkg holds:
  - PS2_FRAME_BITS=11.
  - bit positions START_BIT=0, DATA_LSB=1, DATA_MSB=8, PARITY_BIT=9, STOP_BIT=10.
  - default FIFO_DEPTH and TIMEOUT_CYCLES.
- One sub-module, ps2_rx_fifo: parameterised synchronous FIFO with push/pop/full/empty/count ports and clrn reset.
- Synchroniser, deframer and timeout logic stay in the top module.

Test Plan:
- Drive code 8'h1C with the device model, then hold nextdata_n=1 -> data=8'h1C, ready=1 within 4 clk of the last falling edge; overflow=0; frame_err never pulses.
- Send 8'h1C with the parity bit forced to 1 -> frame_err pulses once for 1 cycle; ready stays 0; the next correct frame 8'hF0 is received normally.
- Send 9 valid codes 8'h01..8'h09 with no reads -> after the 9th frame: overflow=1, 8 entries held; popping yields 01..08 in order; ready=0 after 8 pops; 8'h09 is absent.
- Hold nextdata_n low for exactly 2 cycles with 3 entries held (8'h15, 8'h1D, 8'h24) -> data=8'h24 and ready=1 afterwards. Also pulse nextdata_n while empty -> no state change.
- Send 4 bits of a frame, then idle TIMEOUT_CYCLES clk -> cnt back to 0, no frame_err. A following full frame 8'h5A is received correctly.
- Assert clrn=0 for one cycle in mid-frame with 2 entries queued and overflow=1 -> ready=0, overflow=0, data=8'h00; the next complete frame 8'h29 is received.
